y86_fetch_unit: RTL
===================

# y86_fetch_unit

Upstream instruction-fetch stage for the Y86 SEQ core. Accepts a PC request, reads the byte-wide instruction memory one byte per cycle, decodes instruction length from the first byte, and returns the assembled 80-bit instruction word in the same left-aligned big-endian layout the `seq` core consumes. It also returns the incremented PC (valP) and error/status flags through a valid/ready handshake. It replaces direct combinational indexing of the instruction memory array.

## Interface
- `MEM_BYTES`, 75: bytes of instruction memory; any byte address ≥ `MEM_BYTES` is an imem error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: PC request valid.
- `req_ready` out 1: unit can accept a request (IDLE only).
- `req_pc` in 64: byte address of the instruction.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out 64: byte address.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_rd`.
- `resp_valid` out 1: instruction ready.
- `resp_ready` in 1: consumer accepts.
- `instr` out 80: byte at PC in [79:72], byte PC+k in [79-8k:72-8k], bytes beyond length zero.
- `new_pc` out 64: `req_pc` + length, mod 2^64.
- `instr_len` out 4: 1, 2, 9 or 10.
- `imem_err` out 1: an address ≥ `MEM_BYTES` was required.
- `instr_invalid` out 1: icode > 0xB.

## Operation
- FSM states: IDLE, FETCH, RESP.
- **IDLE:** `req_ready`=1. On `req_valid`, latch the PC, clear the assembly register and counters, and go to FETCH.
- **FETCH:** issue reads at `pc`, `pc+1`, … one per cycle, pipelined. Capture each returned byte into the `instr` slot given by its return index.
- Length comes from the first returned byte's icode:
  - 0 (halt), 1 (nop), 9 (ret): 1
  - 2 (rrmovq/cmovXX), 6 (OPq), 0xA (pushq), 0xB (popq): 2
  - 7 (jXX), 8 (call): 9
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10
  - icode > 0xB: length 1, `instr_invalid`=1
- The length is latched on return of byte 0. Issuing stops once the issued count equals the length.
- For L=1, the one speculative read of `pc+1` is permitted and its data is discarded.
- Before issuing an address ≥ `MEM_BYTES`, suppress the read and set `imem_err`. Once every already-issued byte has returned, go to RESP with unfetched bytes zero. `new_pc` is still `pc + L` if L is known, else `pc + 1`.
- **RESP:** `resp_valid`=1 and all outputs held stable until `resp_ready`, then return to IDLE.
- `req_ready` is 0 in FETCH and RESP. No overlap of requests.
- The address adder wraps mod 2^64. Wrap above `MEM_BYTES` reports `imem_err`.

## Timing
- Reset (async, any state, including mid-fetch): state IDLE; `mem_rd`, `resp_valid`, `imem_err` and `instr_invalid` = 0; `instr`, `new_pc`, `mem_addr` = 0; `instr_len` = 0. A `mem_rdata` return after reset is ignored.
- Cycle 0 is the cycle `req_valid && req_ready`.
- `mem_rd`=1 in cycles 1..L (and cycle 2 for L=1), with address `pc+k-1` in cycle k.
- Byte k is returned in cycle k+1.
- `resp_valid` is first asserted in cycle L+2. Handshake in cycle L+2+w returns to IDLE the next cycle.
- Maximum throughput is one instruction per L+3 cycles.
- `resp_ready` asserted outside RESP has no effect.

## Structure
- Package `y86_pkg`:
  - icode localparams (HALT…POPQ)
  - `ilen(icode)` function returning 4 bits
  - `STAT_AOK/HLT/ADR/INS` codes, shared with `seq`
- Sub-module `y86_ilen_decode`: combinational icode → {len, invalid}. Instantiated once on `mem_rdata[7:4]`.

## Test plan
- **irmovq:** mem[0..9] = 30 F3 00 00 00 00 00 00 00 08, req_pc=0 → cycle 12: `instr`=0x30F3_0000_0000_0000_0008, `new_pc`=10, `instr_len`=10, flags 0.
- **Short instructions:** addq at 20 (60 23) → `instr`=0x6023 followed by 64 zero bits, `new_pc`=22, resp at cycle 4. halt at 43 → `instr_len`=1, `new_pc`=44, resp at cycle 3, only the first byte nonzero.
- **call:** call at 34 (80, bytes 00…00 30) → `instr_len`=9, `new_pc`=43, `instr`[79:8]=0x80_0000_0000_0000_0030, `instr`[7:0]=0.
- **Errors:**
  - byte 0xC0 at pc 5 → `instr_invalid`=1, `instr_len`=1, `new_pc`=6.
  - irmovq at pc 70 with `MEM_BYTES`=75 → `imem_err`=1. `mem_rd` is never asserted with an address ≥ 75. `instr` bytes for addresses 75..79 are zero.
- **Back-pressure:** hold `resp_ready`=0 for 5 cycles → outputs stable and `req_ready`=0 throughout; release → IDLE next cycle.
- **Reset mid-operation:** assert `rst_n`=0 in cycle 4 of an irmovq fetch → all outputs zero immediately. After release, a new request at pc 10 returns 0x30F2_…_0002 correctly, with no stale bytes.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icodes, status codes, fetch FSM states and the length helper
package y86_pkg;
   localparam int MEM_BYTES_DEF = 75;
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   typedef enum logic [1:0] {IDLE, FETCH, RESP} fetch_state_t;
   function automatic logic [3:0] ilen(input logic [3:0] icode);
      return (icode == I_HALT || icode == I_NOP || icode == I_RET) ? 4'd1 :
             (icode == I_RRMOVQ || icode == I_OPQ || icode == I_PUSHQ || icode == I_POPQ) ? 4'd2 :
             (icode == I_JXX || icode == I_CALL) ? 4'd9 :
             (icode >= I_IRMOVQ && icode <= I_MRMOVQ) ? 4'd10 : 4'd1;
   endfunction
endpackage

// File: rtl/y86_fetch_unit_if.sv
// y86_fetch_unit_if: request, memory and response signals of the fetch unit
interface y86_fetch_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_pc;
   logic        mem_rd;
   logic [63:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [79:0] instr;
   logic [63:0] new_pc;
   logic [3:0]  instr_len;
   logic        imem_err;
   logic        instr_invalid;
   modport master (output req_valid, req_pc, mem_rdata, resp_ready,
                   input req_ready, mem_rd, mem_addr, resp_valid, instr, new_pc, instr_len, imem_err, instr_invalid);
   modport slave (input req_valid, req_pc, mem_rdata, resp_ready,
                  output req_ready, mem_rd, mem_addr, resp_valid, instr, new_pc, instr_len, imem_err, instr_invalid);
endinterface

// File: rtl/y86_ilen_decode.sv
// y86_ilen_decode: instruction length and invalid flag from the icode nibble
module y86_ilen_decode
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   output logic [3:0] len,
   output logic       invalid
);
   assign len = ilen(icode);
   assign invalid = icode > I_POPQ;
endmodule

// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: pipelined byte-wide instruction fetch with length decode and handshake
module y86_fetch_unit
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input logic clk,
   input logic rst_n,
   y86_fetch_unit_if.slave bus
);
   fetch_state_t state;
   logic [63:0] pc, iaddr;
   logic [3:0]  iss, rcv, len, dec_len, cur_len, iss_n, rcv_n, fin_len;
   logic        stop, ret_v, inv_q, dec_inv, cur_inv, first, want, oob, issue, stop_n, take, done, req_oob;
   y86_ilen_decode u_dec (.icode(bus.mem_rdata[7:4]), .len(dec_len), .invalid(dec_inv));
   // length is taken live from the decoder on byte 0's return, from the latch afterwards; 0 means unknown
   always_comb begin
      first = ret_v && rcv == 4'd0;
      cur_len = first ? dec_len : len;
      cur_inv = first ? dec_inv : inv_q;
      iaddr = pc + 64'(iss);
      oob = iaddr >= 64'(MEM_BYTES);
      want = !stop && (cur_len == 4'd0 || iss < cur_len);
      issue = want && !oob;
      stop_n = stop || (want && oob);
      iss_n = iss + 4'(issue);
      rcv_n = rcv + 4'(ret_v);
      take = ret_v && rcv < cur_len;
      done = (cur_len != 4'd0 && rcv_n >= cur_len) || (stop_n && rcv_n == iss_n);
      fin_len = cur_len == 4'd0 ? 4'd1 : cur_len;
      req_oob = bus.req_pc >= 64'(MEM_BYTES);
   end
   // fetch FSM: byte 0 is issued on accept, later bytes one per cycle until the length or the memory bound
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         bus.req_ready <= 1'b1;
         bus.mem_rd <= 1'b0;
         bus.mem_addr <= '0;
         bus.resp_valid <= 1'b0;
         bus.instr <= '0;
         bus.new_pc <= '0;
         bus.instr_len <= '0;
         bus.imem_err <= 1'b0;
         bus.instr_invalid <= 1'b0;
         pc <= '0;
         iss <= '0;
         rcv <= '0;
         len <= '0;
         stop <= 1'b0;
         ret_v <= 1'b0;
         inv_q <= 1'b0;
      end else begin
         ret_v <= bus.mem_rd;
         case (state)
            IDLE: if (bus.req_valid) begin
               state <= FETCH;
               bus.req_ready <= 1'b0;
               pc <= bus.req_pc;
               iss <= {3'b0, !req_oob};
               rcv <= '0;
               len <= '0;
               inv_q <= 1'b0;
               stop <= req_oob;
               bus.mem_rd <= !req_oob;
               bus.mem_addr <= bus.req_pc;
               bus.instr <= '0;
               bus.new_pc <= '0;
               bus.instr_len <= '0;
               bus.imem_err <= 1'b0;
               bus.instr_invalid <= 1'b0;
            end
            FETCH: begin
               iss <= iss_n;
               rcv <= rcv_n;
               len <= cur_len;
               inv_q <= cur_inv;
               stop <= stop_n;
               bus.mem_rd <= issue;
               if (issue) bus.mem_addr <= iaddr;
               if (take) bus.instr <= bus.instr | ({bus.mem_rdata, 72'd0} >> {rcv, 3'b0});
               if (done) begin
                  state <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.new_pc <= pc + 64'(fin_len);
                  bus.instr_len <= fin_len;
                  bus.imem_err <= stop_n && (cur_len == 4'd0 || iss_n < cur_len);
                  bus.instr_invalid <= cur_inv;
               end
            end
            default: if (bus.resp_ready) begin
               state <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
